// File: rtl/branch_resolution_unit.sv
// rtl/branch_resolution_unit.sv - resolves predicted next-PCs in ID/EX, drives BTB/BHT updates and redirects
module branch_resolution_unit #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_valid,
  input  logic [WORD_SIZE-1:0] if_pc,
  input  logic [WORD_SIZE-1:0] if_pred_pc,
  input  logic                 stall_id,
  input  logic                 id_is_jump,
  input  logic                 id_is_branch,
  input  logic [WORD_SIZE-1:0] id_target,
  input  logic                 ex_taken,
  output logic                 tag_update,
  output logic [WORD_SIZE-1:0] tag_update_pc,
  output logic [WORD_SIZE-1:0] tag_update_target,
  output logic                 bht_update,
  output logic [WORD_SIZE-1:0] bht_update_pc,
  output logic                 bht_update_taken,
  output logic                 bht_update_correct,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  logic                 r_id_valid;
  logic [WORD_SIZE-1:0] r_id_pc;
  logic [WORD_SIZE-1:0] r_id_pred_pc;

  logic                 r_ex_valid;
  logic [WORD_SIZE-1:0] r_ex_pc;
  logic [WORD_SIZE-1:0] r_ex_pred_pc;
  logic                 r_ex_is_branch;
  logic [WORD_SIZE-1:0] r_ex_target;

  logic [CNT_WIDTH-1:0] r_branch_count;
  logic [CNT_WIDTH-1:0] r_mispredict_count;

  logic                 w_ex_resolve;
  logic [WORD_SIZE-1:0] w_ex_actual;
  logic                 w_ex_correct;
  logic                 w_ex_mispredict;
  logic                 w_id_go;
  logic                 w_id_jump;
  logic                 w_id_branch;
  logic                 w_id_redirect;
  logic [1:0]           w_bc_inc;
  logic [CNT_WIDTH:0]   w_bc_sum;

  assign w_ex_resolve    = r_ex_valid & r_ex_is_branch;
  assign w_ex_actual     = ex_taken ? r_ex_target : r_ex_pc + WORD_SIZE'(1);
  assign w_ex_correct    = (r_ex_pred_pc == w_ex_actual);
  assign w_ex_mispredict = w_ex_resolve & ~w_ex_correct;

  // An EX mispredict belongs to an older instruction, so it silences ID entirely.
  assign w_id_go       = r_id_valid & ~stall_id & ~w_ex_mispredict;
  assign w_id_jump     = w_id_go & id_is_jump;
  assign w_id_branch   = w_id_go & id_is_branch;
  assign w_id_redirect = w_id_jump & (r_id_pred_pc != id_target);

  assign tag_update         = w_id_jump | w_id_branch;
  assign tag_update_pc      = tag_update ? r_id_pc : '0;
  assign tag_update_target  = tag_update ? id_target : '0;

  assign bht_update         = w_ex_resolve;
  assign bht_update_pc      = w_ex_resolve ? r_ex_pc : '0;
  assign bht_update_taken   = w_ex_resolve & ex_taken;
  assign bht_update_correct = w_ex_resolve & w_ex_correct;

  assign redirect_valid = w_ex_mispredict | w_id_redirect;
  assign redirect_pc    = w_ex_mispredict ? w_ex_actual :
                          w_id_redirect   ? id_target   : '0;
  assign flush_if       = redirect_valid;
  assign flush_id       = w_ex_mispredict;

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

  assign w_bc_inc = {1'b0, w_ex_resolve} + {1'b0, w_id_jump};
  assign w_bc_sum = {1'b0, r_branch_count} + {{(CNT_WIDTH-1){1'b0}}, w_bc_inc};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_id_valid         <= 1'b0;
      r_id_pc            <= '0;
      r_id_pred_pc       <= '0;
      r_ex_valid         <= 1'b0;
      r_ex_pc            <= '0;
      r_ex_pred_pc       <= '0;
      r_ex_is_branch     <= 1'b0;
      r_ex_target        <= '0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_ex_valid     <= r_id_valid & ~flush_id & ~stall_id;
      r_ex_pc        <= r_id_pc;
      r_ex_pred_pc   <= r_id_pred_pc;
      r_ex_is_branch <= id_is_branch;
      r_ex_target    <= id_target;

      // flush_id implies flush_if, so loading here always yields an invalid ID slot.
      if (!stall_id || flush_id) begin
        r_id_valid   <= if_valid & ~flush_if;
        r_id_pc      <= if_pc;
        r_id_pred_pc <= if_pred_pc;
      end

      r_branch_count <= w_bc_sum[CNT_WIDTH] ? '1 : w_bc_sum[CNT_WIDTH-1:0];
      if (redirect_valid && (r_mispredict_count != '1))
        r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb/tb_branch_resolution_unit.sv - scoreboard bench for branch_resolution_unit
module tb_branch_resolution_unit;
  localparam int W    = 16;
  localparam int CW   = 16;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic         rst_n;
    logic         if_valid;
    logic [W-1:0] if_pc;
    logic [W-1:0] if_pred;
    logic         stall;
    logic         jump;
    logic         br;
    logic [W-1:0] tgt;
    logic         taken;
  } in_t;

  typedef struct packed {
    logic          tag;
    logic [W-1:0]  tpc;
    logic [W-1:0]  ttgt;
    logic          bht;
    logic [W-1:0]  bpc;
    logic          btk;
    logic          bcor;
    logic          rv;
    logic [W-1:0]  rpc;
    logic          fi;
    logic          fd;
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, if_valid, stall_id, id_is_jump, id_is_branch, ex_taken;
  logic [W-1:0]  if_pc, if_pred_pc, id_target;
  logic          tag_update, bht_update, bht_update_taken, bht_update_correct;
  logic          redirect_valid, flush_if, flush_id;
  logic [W-1:0]  tag_update_pc, tag_update_target, bht_update_pc, redirect_pc;
  logic [CW-1:0] branch_count, mispredict_count;

  branch_resolution_unit #(.WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_pc(if_pred_pc), .stall_id(stall_id), .id_is_jump(id_is_jump),
    .id_is_branch(id_is_branch), .id_target(id_target), .ex_taken(ex_taken),
    .tag_update(tag_update), .tag_update_pc(tag_update_pc),
    .tag_update_target(tag_update_target), .bht_update(bht_update),
    .bht_update_pc(bht_update_pc), .bht_update_taken(bht_update_taken),
    .bht_update_correct(bht_update_correct), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: the instruction sitting in ID and the one sitting in EX.
  bit         id_v, ex_v, ex_br;
  int         id_pc, id_pred, ex_pc, ex_pred, ex_tgt;
  int         m_bc, m_mc;

  function automatic in_t mk(input logic v, input logic [W-1:0] pc, input logic [W-1:0] pred,
                             input logic st, input logic jp, input logic br,
                             input logic [W-1:0] tg, input logic tk);
    in_t s;
    s.rst_n = 1'b1; s.if_valid = v; s.if_pc = pc; s.if_pred = pred;
    s.stall = st; s.jump = jp; s.br = br; s.tgt = tg; s.taken = tk;
    return s;
  endfunction

  function automatic in_t rnd();
    in_t s;
    int  k;
    s.rst_n    = ($urandom_range(0, 199) != 0);
    s.if_valid = ($urandom_range(0, 3) != 0);
    s.if_pc    = W'($urandom);
    k          = $urandom_range(0, 2);
    s.if_pred  = (k == 0) ? s.if_pc + W'(1) : (k == 1) ? W'($urandom_range(0, 7)) : W'($urandom);
    s.stall    = ($urandom_range(0, 4) == 0);
    k          = $urandom_range(0, 2);
    s.jump     = (k == 0);
    s.br       = (k == 1);
    s.tgt      = ($urandom_range(0, 1) == 1) ? W'(id_pred) : W'($urandom);
    s.taken    = ($urandom_range(0, 1) == 1);
    return s;
  endfunction

  task automatic step(input in_t s);
    exp_t e;
    int   actual;
    bit   ex_wrong, id_jump_done;
    bit   nid_v;
    reset_n = s.rst_n; if_valid = s.if_valid; if_pc = s.if_pc; if_pred_pc = s.if_pred;
    stall_id = s.stall; id_is_jump = s.jump; id_is_branch = s.br; id_target = s.tgt;
    ex_taken = s.taken;

    e = '0;
    ex_wrong = 0;
    id_jump_done = 0;
    if (ex_v && ex_br) begin
      actual = s.taken ? ex_tgt : (ex_pc + 1) % (1 << W);
      e.bht  = 1; e.bpc = W'(ex_pc); e.btk = s.taken; e.bcor = (ex_pred == actual);
      if (ex_pred != actual) begin
        ex_wrong = 1; e.rv = 1; e.rpc = W'(actual); e.fi = 1; e.fd = 1;
      end
    end
    if (id_v && !s.stall && !ex_wrong && (s.jump || s.br)) begin
      e.tag = 1; e.tpc = W'(id_pc); e.ttgt = s.tgt;
      id_jump_done = s.jump;
      if (s.jump && id_pred != int'(s.tgt)) begin
        e.rv = 1; e.rpc = s.tgt; e.fi = 1;
      end
    end
    e.bc = CW'(m_bc);
    e.mc = CW'(m_mc);
    q.push_back(e);

    if (!s.rst_n) begin
      id_v = 0; ex_v = 0; m_bc = 0; m_mc = 0;
    end else begin
      m_bc = m_bc + int'(e.bht) + int'(id_jump_done);
      if (m_bc > MAXC) m_bc = MAXC;
      m_mc = m_mc + int'(e.rv);
      if (m_mc > MAXC) m_mc = MAXC;
      nid_v = id_v;
      ex_v  = id_v && !e.fd && !s.stall;
      ex_pc = id_pc; ex_pred = id_pred; ex_br = s.br; ex_tgt = int'(s.tgt);
      if (!s.stall || e.fd) begin
        nid_v = s.if_valid && !e.fi;
        id_pc = int'(s.if_pc); id_pred = int'(s.if_pred);
      end
      id_v = nid_v;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [70:0] act, req;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {tag_update, tag_update_pc, tag_update_target, bht_update, bht_update_pc,
             bht_update_taken, bht_update_correct, redirect_valid, redirect_pc, flush_if, flush_id};
      req = {e.tag, e.tpc, e.ttgt, e.bht, e.bpc, e.btk, e.bcor, e.rv, e.rpc, e.fi, e.fd};
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, act, req);
      n_checks++;
      if ({branch_count, mispredict_count} === {e.bc, e.mc}) n_pass++;
      else $display("FAIL counters cyc=%0d actual bc=%h mc=%h required bc=%h mc=%h",
                    cyc, branch_count, mispredict_count, e.bc, e.mc);
    end
  end

  initial begin
    in_t s;
    reset_n = 0; if_valid = 0; if_pc = 0; if_pred_pc = 0; stall_id = 0;
    id_is_jump = 0; id_is_branch = 0; id_target = 0; ex_taken = 0;
    id_v = 0; ex_v = 0; ex_br = 0; id_pc = 0; id_pred = 0; ex_pc = 0; ex_pred = 0; ex_tgt = 0;
    m_bc = 0; m_mc = 0;
    repeat (2) @(posedge clk);
    #1;
    idle(2);

    step(mk(1'b1, 16'h0010, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
    step(mk(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b0));
    idle(1);

    step(mk(1'b1, 16'h0010, 16'h0011, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
    step(mk(1'b1, 16'h0011, 16'h0012, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b0));
    step(mk(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0099, 1'b1));
    idle(2);

    step(mk(1'b1, 16'h0020, 16'h0030, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
    step(mk(1'b1, 16'h0021, 16'h0050, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b0));
    step(mk(1'b1, 16'h0022, 16'h0023, 1'b0, 1'b1, 1'b0, 16'h0051, 1'b0));
    idle(2);

    step(mk(1'b1, 16'h0060, 16'h0070, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
    for (int i = 0; i < 3; i++) step(mk(1'b1, 16'h0061, 16'h0062, 1'b1, 1'b1, 1'b0, 16'h0070, 1'b0));
    step(mk(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0070, 1'b0));
    idle(2);

    step(mk(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
    step(mk(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0));
    idle(2);

    step(mk(1'b1, 16'h0080, 16'h0090, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
    step(mk(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0090, 1'b0));
    s = mk(1'b1, 16'h0081, 16'h0082, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    s.rst_n = 1'b0;
    step(s);
    idle(2);

    for (int i = 0; i < 3000; i++) step(rnd());

    // One correctly predicted jump per cycle drives branch_count into saturation.
    for (int i = 0; i < 65600; i++)
      step(mk(1'b1, W'(i), 16'h0100, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b0));
    for (int i = 0; i < 500; i++) begin
      s = rnd();
      s.rst_n = 1'b1;
      step(s);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
